hazard_unit: RTL and testbench

//  Pipeline control for the 5-stage core. Drives the write/flush pins of the IF/ID register and PC,

---
 rtl/core_pkg.sv | 11 +
 rtl/sat_counter.sv | 21 ++
 rtl/hazard_unit.sv | 115 +++++++++++
 tb/tb_hazard_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline control: the FSM state encoding and
// register-file constants.
package core_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_X0 = 5'd0;

  typedef enum logic {
    RUN  = 1'b0,
    LONG = 1'b1
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping. It is cleared by a
// synchronous reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] value
);
  logic [W-1:0] r_value;

  always_ff @(posedge clk) begin
    if (reset)
      r_value <= '0;
    else if (inc && (r_value != {W{1'b1}}))
      r_value <= r_value + W'(1);
  end

  assign value = r_value;
endmodule

// File: rtl/hazard_unit.sv
// Pipeline control for the 5-stage core. It handles load-use stalls, branch
// redirect flushes and multi-cycle EX sequencing, and it keeps stall and flush
// performance counters.
module hazard_unit
  import core_pkg::*;
#(
  parameter int LONG_LAT = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_long_op,
  input  logic             ex_valid,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             ex_hold,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_flush
);
  localparam int LW = (LONG_LAT > 2) ? $clog2(LONG_LAT) : 1;
  localparam logic [LW-1:0] CNT_LOAD = LW'(LONG_LAT - 2);

  state_t        r_state;
  logic [LW-1:0] r_cnt;

  logic w_redirect, w_match, w_load_use, w_long_req;
  logic w_pc_write, w_ifid_write, w_ifid_flush, w_idex_flush, w_ex_hold;

  assign w_redirect = ex_valid & ex_branch_taken;
  assign w_match    = (id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd));
  assign w_load_use = ex_valid & ex_mem_read & (ex_rd != REG_X0) & id_valid & w_match;
  assign w_long_req = id_valid & id_long_op;

  always_comb begin
    w_pc_write   = 1'b1;
    w_ifid_write = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_ex_hold    = 1'b0;
    if (reset) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
    end else if (r_state == LONG) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_ex_hold    = 1'b1;
    end else if (w_redirect) begin
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
    end else if (w_load_use) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_idex_flush = 1'b1;
    end
  end

  // A long op entering EX on the final LONG cycle reloads the counter directly.
  // This keeps ex_hold continuous across back-to-back ops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (!w_redirect && !w_load_use && w_long_req) begin
            r_state <= LONG;
            r_cnt   <= CNT_LOAD;
          end
        end
        LONG: begin
          if (r_cnt == '0) begin
            if (w_long_req) r_cnt <= CNT_LOAD;
            else            r_state <= RUN;
          end else begin
            r_cnt <= r_cnt - LW'(1);
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign pc_write   = w_pc_write;
  assign ifid_write = w_ifid_write;
  assign ifid_flush = w_ifid_flush;
  assign idex_flush = w_idex_flush;
  assign ex_hold    = w_ex_hold;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~w_pc_write),
    .value (perf_stall)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_ifid_flush),
    .value (perf_flush)
  );
endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit. It drives a vector table and keeps a
// scoreboard queue of the expected control outputs. A counter model runs a
// 32-bit instance and a 2-bit instance side by side to check saturation.
module tb_hazard_unit;
  logic       clk, reset;
  logic       id_valid, id_use_rs1, id_use_rs2, id_long_op;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_valid, ex_mem_read, ex_branch_taken;

  logic        pc_write, ifid_write, ifid_flush, idex_flush, ex_hold;
  logic [31:0] perf_stall, perf_flush;
  logic        pc_write2, ifid_write2, ifid_flush2, idex_flush2, ex_hold2;
  logic [1:0]  perf_stall2, perf_flush2;

  hazard_unit #(.LONG_LAT(4), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_long_op(id_long_op),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .ex_hold(ex_hold),
    .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  hazard_unit #(.LONG_LAT(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_long_op(id_long_op),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .pc_write(pc_write2), .ifid_write(ifid_write2),
    .ifid_flush(ifid_flush2), .idex_flush(idex_flush2), .ex_hold(ex_hold2),
    .perf_stall(perf_stall2), .perf_flush(perf_flush2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The environment must never present a load or a redirect while EX is held.
  always @(negedge clk)
    if (!reset) assert (!(ex_hold && (ex_branch_taken || ex_mem_read)))
      else $error("illegal load/redirect during long op");

  typedef struct {
    logic       rst, idv;
    logic [4:0] rs1, rs2;
    logic       u1, u2, lng, exv;
    logic [4:0] rd;
    logic       mr, bt;
    logic [4:0] o;  // {pc_write, ifid_write, ifid_flush, idex_flush, ex_hold}
  } vec_t;

  localparam logic [4:0] NRM = 5'b11000;
  localparam logic [4:0] STL = 5'b00010;
  localparam logic [4:0] FLS = 5'b11110;
  localparam logic [4:0] HLD = 5'b00001;
  localparam logic [4:0] RST = 5'b00110;

  vec_t tbl[$];
  vec_t sb[$];
  int   total = 0, passed = 0;
  int   m_ps = 0, m_pf = 0, m_ps2 = 0;

  function automatic vec_t mk(input logic rst, idv, input logic [4:0] rs1, rs2,
                              input logic u1, u2, lng, exv, input logic [4:0] rd,
                              input logic mr, bt, input logic [4:0] o);
    vec_t v;
    v.rst = rst; v.idv = idv; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.lng = lng; v.exv = exv; v.rd = rd; v.mr = mr; v.bt = bt; v.o = o;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s vec%0d: got %0h expected %0h", nm, idx, act, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,NRM));
  endtask

  task automatic long_hold(input int n, input logic lng_last);
    for (int i = 0; i < n; i++)
      tbl.push_back(mk(0,1,1,2,1,1,(i == n-1) ? lng_last : 1'b0,0,0,0,0,HLD));
  endtask

  initial begin
    // 1: reset for 3 cycles, then idle
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,RST));
    idle(2);
    // 2: lw x5 in EX, add reading x5 via rs2 -> one bubble
    tbl.push_back(mk(0,1,3,5,1,1,0,1,5,1,0,STL));
    tbl.push_back(mk(0,1,3,5,1,1,0,0,0,0,0,NRM));
    idle(1);
    // 3: x0 destination, unused rs2, no EX valid, no ID valid -> no stall
    tbl.push_back(mk(0,1,0,0,1,1,0,1,0,1,0,NRM));
    tbl.push_back(mk(0,1,3,5,1,0,0,1,5,1,0,NRM));
    tbl.push_back(mk(0,1,3,5,1,1,0,0,5,1,0,NRM));
    tbl.push_back(mk(0,0,3,5,1,1,0,1,5,1,0,NRM));
    // rs1 match also stalls
    tbl.push_back(mk(0,1,7,2,1,1,0,1,7,1,0,STL));
    tbl.push_back(mk(0,1,7,2,1,1,0,0,0,0,0,NRM));
    // 4: redirect wins over a simultaneous load-use
    tbl.push_back(mk(0,1,3,5,0,1,0,1,5,1,1,FLS));
    idle(1);
    // 5: single long op -> 3 hold cycles
    tbl.push_back(mk(0,1,1,2,1,1,1,0,0,0,0,NRM));
    long_hold(3, 1'b0);
    idle(1);
    // back-to-back long ops -> 6 contiguous hold cycles
    tbl.push_back(mk(0,1,1,2,1,1,1,0,0,0,0,NRM));
    long_hold(3, 1'b1);
    long_hold(3, 1'b0);
    idle(1);
    // long op blocked by load-use takes the bubble first, then enters LONG
    tbl.push_back(mk(0,1,5,2,1,0,1,1,5,1,0,STL));
    tbl.push_back(mk(0,1,5,2,1,0,1,0,0,0,0,NRM));
    long_hold(3, 1'b0);
    idle(1);
    // 6: reset on the 2nd LONG cycle aborts the sequence
    tbl.push_back(mk(0,1,1,2,1,1,1,0,0,0,0,NRM));
    long_hold(1, 1'b0);
    tbl.push_back(mk(1,1,1,2,1,1,0,0,0,0,0,RST));
    idle(2);
    // five stalls: the 2-bit instance saturates at 3
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(mk(0,1,4,9,1,1,0,1,9,1,0,STL));
      tbl.push_back(mk(0,1,4,9,1,1,0,0,0,0,0,NRM));
    end
    idle(1);

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t e;
      reset = tbl[i].rst; id_valid = tbl[i].idv; id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2;
      id_use_rs1 = tbl[i].u1; id_use_rs2 = tbl[i].u2; id_long_op = tbl[i].lng;
      ex_valid = tbl[i].exv; ex_rd = tbl[i].rd; ex_mem_read = tbl[i].mr;
      ex_branch_taken = tbl[i].bt;
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk("pc_write",   i, {31'd0, pc_write},   {31'd0, e.o[4]});
      chk("ifid_write", i, {31'd0, ifid_write}, {31'd0, e.o[3]});
      chk("ifid_flush", i, {31'd0, ifid_flush}, {31'd0, e.o[2]});
      chk("idex_flush", i, {31'd0, idex_flush}, {31'd0, e.o[1]});
      chk("ex_hold",    i, {31'd0, ex_hold},    {31'd0, e.o[0]});
      chk("perf_stall", i, perf_stall, m_ps);
      chk("perf_flush", i, perf_flush, m_pf);
      chk("perf_stall_sat", i, {30'd0, perf_stall2}, m_ps2);
      @(posedge clk);
      if (e.rst) begin
        m_ps = 0; m_pf = 0; m_ps2 = 0;
      end else begin
        if (!e.o[4]) begin
          m_ps++;
          if (m_ps2 < 3) m_ps2++;
        end
        if (e.o[2]) m_pf++;
      end
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
